matrix_rx: RTL

MATRIX_RX -- requirements
Module: matrix_rx

---
 rtl/matrix_pkg.sv | 16 +
 rtl/sync_edge.sv | 52 +++++
 rtl/matrix_rx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants and types for the matrix serial receiver
package matrix_pkg;

    localparam int ROWS_DEFAULT  = 16;
    localparam int COLS_DEFAULT  = 16;
    localparam int RD_ROW_W      = 4;
    localparam int FRAME_COUNT_W = 8;

    // Classification of the latched row-select word at a write event
    typedef enum logic [1:0] {
        ROW_NONE  = 2'd0,
        ROW_ONE   = 2'd1,
        ROW_MULTI = 2'd2
    } row_sel_e;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - per-pin sampler with rise/fall detect; MATRIX_RX_SYNC_EN adds a 2-flop synchronizer
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sample_src;
    logic sample_q;
    logic prev_q;

`ifdef MATRIX_RX_SYNC_EN
    logic meta_q;
    logic stable_q;

    // Two-flop synchronizer for pins from an unrelated clock domain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q   <= RESET_VAL;
            stable_q <= RESET_VAL;
        end else begin
            meta_q   <= din;
            stable_q <= meta_q;
        end
    end

    assign sample_src = stable_q;
`else
    assign sample_src = din;
`endif

    // Sample and previous-sample registers; preset so no edge appears right after reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sample_q <= RESET_VAL;
            prev_q   <= RESET_VAL;
        end else begin
            sample_q <= sample_src;
            prev_q   <= sample_q;
        end
    end

    assign level = sample_q;
    assign rise  = sample_q & ~prev_q;
    assign fall  = ~sample_q & prev_q;

endmodule

// File: rtl/matrix_rx.sv
// rtl/matrix_rx.sv - LED matrix serial receiver with frame buffer (optional MATRIX_RX_SYNC_EN input sync)
module matrix_rx
    import matrix_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT,
    parameter int COLS = COLS_DEFAULT
) (
    input  logic                     clk32mhz,
    input  logic                     reset_n,
    input  logic                     CCLK,
    input  logic                     CSDI,
    input  logic                     RCLK,
    input  logic                     RSDI,
    input  logic                     LE,
    input  logic                     OEB,
    input  logic [RD_ROW_W-1:0]      rd_row,
    output logic [COLS-1:0]          rd_data,
    output logic                     frame_done,
    output logic [FRAME_COUNT_W-1:0] frame_count,
    output logic                     row_err
);

    logic cclk_rise, rclk_rise, le_rise, oeb_fall;
    logic csdi_lvl, rsdi_lvl;
    logic cclk_lvl_unused, cclk_fall_unused, rclk_lvl_unused, rclk_fall_unused;
    logic le_lvl_unused, le_fall_unused, oeb_lvl_unused, oeb_rise_unused;
    logic csdi_rise_unused, csdi_fall_unused, rsdi_rise_unused, rsdi_fall_unused;

    sync_edge #(.RESET_VAL(1'b0)) u_cclk (.clk(clk32mhz), .reset_n(reset_n), .din(CCLK),
        .level(cclk_lvl_unused), .rise(cclk_rise), .fall(cclk_fall_unused));
    sync_edge #(.RESET_VAL(1'b0)) u_csdi (.clk(clk32mhz), .reset_n(reset_n), .din(CSDI),
        .level(csdi_lvl), .rise(csdi_rise_unused), .fall(csdi_fall_unused));
    sync_edge #(.RESET_VAL(1'b0)) u_rclk (.clk(clk32mhz), .reset_n(reset_n), .din(RCLK),
        .level(rclk_lvl_unused), .rise(rclk_rise), .fall(rclk_fall_unused));
    sync_edge #(.RESET_VAL(1'b0)) u_rsdi (.clk(clk32mhz), .reset_n(reset_n), .din(RSDI),
        .level(rsdi_lvl), .rise(rsdi_rise_unused), .fall(rsdi_fall_unused));
    sync_edge #(.RESET_VAL(1'b0)) u_le (.clk(clk32mhz), .reset_n(reset_n), .din(LE),
        .level(le_lvl_unused), .rise(le_rise), .fall(le_fall_unused));
    sync_edge #(.RESET_VAL(1'b1)) u_oeb (.clk(clk32mhz), .reset_n(reset_n), .din(OEB),
        .level(oeb_lvl_unused), .rise(oeb_rise_unused), .fall(oeb_fall));

    logic [COLS-1:0]          col_sr_q, col_sr_d, col_lat_q, col_lat_d;
    logic [ROWS-1:0]          row_sr_q, row_sr_d, row_lat_q, row_lat_d;
    logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;
    logic                     frame_done_q, frame_done_d;
    logic                     row_err_q, row_err_d;
    logic [COLS-1:0]          fb_q [ROWS];
    row_sel_e                 row_sel;
    logic                     wr_en;

    // Classify the latched row word: a write needs exactly one row selected
    always_comb begin
        row_sel = ROW_NONE;
        if (row_lat_q != '0) begin
            if ((row_lat_q & (row_lat_q - ROWS'(1))) == '0) begin
                row_sel = ROW_ONE;
            end else begin
                row_sel = ROW_MULTI;
            end
        end
    end

    assign wr_en = oeb_fall && (row_sel == ROW_ONE);

    // Next-state for shifters, latches, frame counter and error flag
    always_comb begin
        col_sr_d      = col_sr_q;
        row_sr_d      = row_sr_q;
        col_lat_d     = col_lat_q;
        row_lat_d     = row_lat_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;
        row_err_d     = row_err_q;
        if (cclk_rise) begin
            col_sr_d = {col_sr_q[COLS-2:0], csdi_lvl};
        end
        if (rclk_rise) begin
            row_sr_d = {row_sr_q[ROWS-2:0], rsdi_lvl};
        end
        // Latch the post-shift value so a shift in the LE cycle is included
        if (le_rise) begin
            col_lat_d = col_sr_d;
            row_lat_d = row_sr_d;
        end
        if (oeb_fall && (row_sel == ROW_MULTI)) begin
            row_err_d = 1'b1;
        end
        if (wr_en && row_lat_q[ROWS-1]) begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + FRAME_COUNT_W'(1);
        end
    end

    // Control state registers
    always_ff @(posedge clk32mhz) begin
        if (!reset_n) begin
            col_sr_q      <= '0;
            row_sr_q      <= '0;
            col_lat_q     <= '0;
            row_lat_q     <= '0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
            row_err_q     <= 1'b0;
        end else begin
            col_sr_q      <= col_sr_d;
            row_sr_q      <= row_sr_d;
            col_lat_q     <= col_lat_d;
            row_lat_q     <= row_lat_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
            row_err_q     <= row_err_d;
        end
    end

    // Frame buffer: store column latch into the single selected row
    always_ff @(posedge clk32mhz) begin
        for (int i = 0; i < ROWS; i++) begin
            if (!reset_n) begin
                fb_q[i] <= '0;
            end else if (wr_en && row_lat_q[i]) begin
                fb_q[i] <= col_lat_q;
            end
        end
    end

    assign rd_data     = (32'(rd_row) < ROWS) ? fb_q[rd_row] : '0;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign row_err     = row_err_q;

endmodule
